// File: rtl/lut_ram_mp.sv
// Multi-read-port LUT RAM: one byte-enabled synchronous write port, NUM_RD_PORTS
// combinational read ports, optional write bypass, and a post-reset clear sequencer.

module lut_ram_mp_rdport #(
  parameter int W      = 32,
  parameter int NB     = W/8,
  parameter bit BYPASS = 1'b0
) (
  input  logic          ready,
  input  logic          hit,
  input  logic [W-1:0]  mem_word,
  input  logic [W-1:0]  wr_data,
  input  logic [NB-1:0] wr_be,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] merged;

  always_comb begin
    merged = mem_word;
    if (BYPASS && hit)
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
    rd_data = ready ? merged : '0;
  end
endmodule

module lut_ram_mp #(
  parameter int LUT_WIDTH    = 32,
  parameter int LUT_DEPTH    = 256,
  parameter int NUM_RD_PORTS = 2,
  parameter bit WR_BYPASS    = 1'b0
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                wr_en,
  input  logic [$clog2(LUT_DEPTH)-1:0]                        wr_addr,
  input  logic [LUT_WIDTH-1:0]                                wr_data,
  input  logic [LUT_WIDTH/8-1:0]                              wr_be,
  input  logic [NUM_RD_PORTS-1:0][$clog2(LUT_DEPTH)-1:0]      rd_addr,
  output logic [NUM_RD_PORTS-1:0][LUT_WIDTH-1:0]              rd_data,
  output logic                                                init_busy
);
  localparam int AW = $clog2(LUT_DEPTH);
  localparam int NB = LUT_WIDTH/8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [AW-1:0]           clr_addr;
  logic [LUT_WIDTH-1:0]    mem [LUT_DEPTH];
  logic                    ready;
  logic [NUM_RD_PORTS-1:0] rd_hit;

  assign ready = (state == READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      init_busy <= 1'b1;
    end else if (state == CLEAR) begin
      if (clr_addr == AW'(LUT_DEPTH-1)) begin
        state     <= READY;
        clr_addr  <= '0;
        init_busy <= 1'b0;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  // Storage has no reset; the sequencer zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[clr_addr] <= '0;
      else if (wr_en)
        for (int b = 0; b < NB; b++)
          if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
    assign rd_hit[i] = wr_en && (rd_addr[i] == wr_addr);

    lut_ram_mp_rdport #(.W(LUT_WIDTH), .NB(NB), .BYPASS(WR_BYPASS)) u_rd (
      .ready    (ready),
      .hit      (rd_hit[i]),
      .mem_word (mem[rd_addr[i]]),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .rd_data  (rd_data[i])
    );
  end
endmodule

// File: tb/tb_lut_ram_mp.sv
// Directed bench for lut_ram_mp: a bypass and a non-bypass instance share all inputs;
// expected values are queued when stimulus is driven and popped when outputs are sampled.

module tb_lut_ram_mp;
  localparam int W = 32, D = 256, P = 2, AW = 8, NB = 4;

  logic                   clk = 1'b0;
  logic                   rst, wr_en;
  logic [AW-1:0]          wr_addr;
  logic [W-1:0]           wr_data;
  logic [NB-1:0]          wr_be;
  logic [P-1:0][AW-1:0]   rd_addr;
  logic [P-1:0][W-1:0]    rd_b, rd_n;
  logic                   busy_b, busy_n;

  int n_chk = 0, n_err = 0;

  typedef struct { string tag; logic [W-1:0] val; } exp_t;
  exp_t exp_q[$];

  lut_ram_mp #(.LUT_WIDTH(W), .LUT_DEPTH(D), .NUM_RD_PORTS(P), .WR_BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rd_b), .init_busy(busy_b));

  lut_ram_mp #(.LUT_WIDTH(W), .LUT_DEPTH(D), .NUM_RD_PORTS(P), .WR_BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rd_n), .init_busy(busy_n));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input string tag, input logic [W-1:0] v);
    exp_t e;
    e.tag = tag; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [W-1:0] obs);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NB-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  // Reads addr a on port 0 of both instances (no write in flight).
  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
    rd_addr[0] = a;
    push({tag, "_byp"}, exp);
    push({tag, "_nb"}, exp);
    #1;
    pop_chk(rd_b[0]);
    pop_chk(rd_n[0]);
  endtask

  // Runs the clear with rd ports watched; returns cycles until init_busy drops.
  task automatic run_clear(input string tag, output int cyc);
    logic nz;
    nz = 1'b0;
    cyc = 0;
    while ((busy_b || busy_n) && cyc < 1000) begin
      if (rd_b != '0 || rd_n != '0) nz = 1'b1;
      rd_addr[0] = AW'(cyc); rd_addr[1] = AW'(255 - cyc);
      tick();
      cyc++;
    end
    push({tag, "_rd_zero_during_clear"}, 32'd0);
    pop_chk({31'd0, nz});
    push({tag, "_busy_nb_cycles"}, 32'd256);
    pop_chk(32'(cyc));
  endtask

  initial begin
    int cyc;
    logic bad;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;

    // Reset state; user writes to addr 9 held on through the whole clear
    tick();
    tick();
    rst = 1'b0;
    push("reset_busy", 32'd1);     pop_chk({31'd0, busy_b});
    push("reset_rd_zero", 32'd0);  pop_chk(rd_b[0] | rd_b[1] | rd_n[0] | rd_n[1]);
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 32'h1234; wr_be = 4'hF;
    run_clear("clear1", cyc);
    wr_en = 1'b0;
    push("busy_match", 32'd0);     pop_chk({31'd0, busy_b ^ busy_n});
    rd_chk("wr_during_clear_dropped", 8'd9, 32'h0);

    // Byte enables
    wr(8'd5, 32'hDEADBEEF, 4'hF);
    wr(8'd5, 32'h11223344, 4'b0101);
    rd_chk("byte_en", 8'd5, 32'hDE22BE44);
    wr(8'd5, 32'hFFFFFFFF, 4'h0);
    rd_chk("be_zero_noop", 8'd5, 32'hDE22BE44);

    // Multi-port read
    wr(8'd3, 32'hA5, 4'hF);
    wr(8'd200, 32'h5A, 4'hF);
    rd_addr[0] = 8'd3; rd_addr[1] = 8'd200; #1;
    push("mp_p0", 32'hA5); pop_chk(rd_b[0]);
    push("mp_p1", 32'h5A); pop_chk(rd_n[1]);
    rd_addr[0] = 8'd200; #1;
    push("mp_same_p0", 32'h5A); pop_chk(rd_n[0]);
    push("mp_same_p1", 32'h5A); pop_chk(rd_b[1]);

    // Bypass vs no bypass on the same-cycle write
    wr(8'd7, 32'hFFFFFFFF, 4'hF);
    rd_addr[0] = 8'd7; rd_addr[1] = 8'd3;
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'h12; wr_be = 4'b0001;
    #1;
    push("bypass_same_cycle", 32'hFFFFFF12); pop_chk(rd_b[0]);
    push("nobypass_same_cycle", 32'hFFFFFFFF); pop_chk(rd_n[0]);
    push("bypass_other_port", 32'hA5); pop_chk(rd_b[1]);
    tick();
    wr_en = 1'b0;
    rd_chk("after_write_edge", 8'd7, 32'hFFFFFF12);

    // Preload nonzero, reset 2 cycles, clear, verify every address is zero
    wr(8'd0, 32'h01020304, 4'hF);
    wr(8'd255, 32'hCAFEF00D, 4'hF);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    run_clear("clear2", cyc);
    bad = 1'b0;
    for (int a = 0; a < D; a++) begin
      rd_addr[0] = AW'(a); rd_addr[1] = AW'(a); #1;
      if (rd_b != '0 || rd_n != '0) bad = 1'b1;
    end
    push("all_zero_after_clear", 32'd0); pop_chk({31'd0, bad});

    // Reset mid-clear restarts the full sequence
    wr(8'd42, 32'h55AA55AA, 4'hF);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    push("midclear_still_busy", 32'd1); pop_chk({31'd0, busy_b & busy_n});
    rst = 1'b1; tick(); rst = 1'b0;
    run_clear("clear_restart", cyc);
    rd_chk("midclear_zeroed", 8'd42, 32'h0);
    wr(8'd42, 32'h0BADBEEF, 4'hF);
    rd_chk("first_write_after_clear", 8'd42, 32'h0BADBEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
